// File: rtl/csr_issue_ctrl_pkg.sv
// Shared types and constants for the CSR issue controller: FSM states,
// Zicsr funct3 encodings and the bit positions inside csr_op.
package csr_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  localparam logic [2:0] CSRRW  = 3'b001;
  localparam logic [2:0] CSRRS  = 3'b010;
  localparam logic [2:0] CSRRC  = 3'b011;
  localparam logic [2:0] CSRRWI = 3'b101;
  localparam logic [2:0] CSRRSI = 3'b110;
  localparam logic [2:0] CSRRCI = 3'b111;

  // csr_op bit positions: bit1 = read, bit0 = write
  localparam int CSR_OP_R = 1;
  localparam int CSR_OP_W = 0;

endpackage

// File: rtl/csr_issue_ctrl_if.sv
// Request, CSR-bus and writeback signals of the CSR issue controller.
// Handshakes: a transfer happens on the rising clk edge where valid and
// ready (req_valid/req_ready, wb_valid/wb_ready, csr_rvalid/csr_rrsp) are
// both high; csr_valid is a single-cycle command pulse with no ready.
interface csr_issue_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int REG_WIDTH  = 32
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic [2:0]            req_funct3;
  logic [4:0]            req_rs1_idx;
  logic [REG_WIDTH-1:0]  req_rs1_val;
  logic [ADDR_WIDTH-1:0] req_csr_addr;
  logic [4:0]            req_rd_idx;

  logic [1:0]            csr_op;
  logic [2:0]            csr_funct3;
  logic [4:0]            csr_imm;
  logic [REG_WIDTH-1:0]  rs1_val;
  logic [ADDR_WIDTH-1:0] csr_addr;
  logic                  csr_valid;
  logic                  csr_rrsp;
  logic [ADDR_WIDTH-1:0] csr_rdata;
  logic                  csr_rvalid;
  logic                  csr_reg_rsp;

  logic                  wb_valid;
  logic                  wb_ready;
  logic [4:0]            wb_rd_idx;
  logic [REG_WIDTH-1:0]  wb_data;
  logic                  wb_exc;
  logic                  wb_timeout;

  logic                  flush;

  // controller side
  modport slave (
    input  req_valid, req_funct3, req_rs1_idx, req_rs1_val, req_csr_addr, req_rd_idx,
    output req_ready,
    output csr_op, csr_funct3, csr_imm, rs1_val, csr_addr, csr_valid, csr_rrsp,
    input  csr_rdata, csr_rvalid, csr_reg_rsp,
    output wb_valid, wb_rd_idx, wb_data, wb_exc, wb_timeout,
    input  wb_ready,
    input  flush
  );

  // environment side (pipeline front end, CSR target, writeback)
  modport master (
    output req_valid, req_funct3, req_rs1_idx, req_rs1_val, req_csr_addr, req_rd_idx,
    input  req_ready,
    input  csr_op, csr_funct3, csr_imm, rs1_val, csr_addr, csr_valid, csr_rrsp,
    output csr_rdata, csr_rvalid, csr_reg_rsp,
    input  wb_valid, wb_rd_idx, wb_data, wb_exc, wb_timeout,
    output wb_ready,
    output flush
  );

endinterface

// File: rtl/csr_issue_ctrl_op_decode.sv
// Combinational funct3/rd/rs1 decode into the csr_op read/write bits.
// funct3 000 and 100 are flagged illegal and produce csr_op = 00.
module csr_op_decode
  import csr_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [4:0] rd_idx,
  input  logic [4:0] rs1_idx,
  output logic [1:0] op,
  output logic       illegal
);

  always_comb begin
    op      = 2'b00;
    illegal = 1'b0;
    case (funct3)
      // swaps always write; the read is suppressed when rd is x0
      CSRRW, CSRRWI: begin
        op[CSR_OP_W] = 1'b1;
        op[CSR_OP_R] = (rd_idx != 5'd0);
      end
      // set/clear always read; a zero rs1/uimm makes them read-only
      CSRRS, CSRRC, CSRRSI, CSRRCI: begin
        op[CSR_OP_R] = 1'b1;
        op[CSR_OP_W] = (rs1_idx != 5'd0);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/csr_issue_ctrl.sv
// CSR instruction issue controller: accepts one Zicsr request, issues it
// on the CSR bus, waits for the response (or times out) and writes back.
module csr_issue_ctrl
  import csr_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  csr_issue_ctrl_if.slave  bus,
  output state_t           dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t state, state_n;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            op_q;
  logic [2:0]            funct3_q;
  logic [4:0]            imm_q;
  logic [REG_WIDTH-1:0]  rs1_q;
  logic [4:0]            rd_q;
  logic [REG_WIDTH-1:0]  wb_data_q;
  logic                  wb_exc_q;
  logic                  wb_timeout_q;
  logic [CNT_W-1:0]      cnt, cnt_inc;

  logic [1:0] dec_op;
  logic       dec_illegal;

  logic req_ready, csr_valid, csr_rrsp, wb_valid;
  logic accept, rsp_take, to_take, cnt_en, timeout_hit, bus_active;

  csr_op_decode u_decode (
    .funct3  (bus.req_funct3),
    .rd_idx  (bus.req_rd_idx),
    .rs1_idx (bus.req_rs1_idx),
    .op      (dec_op),
    .illegal (dec_illegal)
  );

  // saturating count of WAIT/DRAIN cycles since the command was issued
  assign cnt_inc     = (cnt == CNT_W'(TIMEOUT_CYCLES)) ? cnt : cnt + CNT_W'(1);
  assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    csr_valid = 1'b0;
    csr_rrsp  = 1'b0;
    wb_valid  = 1'b0;
    accept    = 1'b0;
    rsp_take  = 1'b0;
    to_take   = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid && !bus.flush) begin
          accept  = 1'b1;
          state_n = dec_illegal ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        csr_valid = 1'b1;
        csr_rrsp  = bus.csr_rvalid;
        if (bus.csr_rvalid) begin
          if (bus.flush) state_n = IDLE;
          else begin
            rsp_take = 1'b1;
            state_n  = RESP;
          end
        end else if (bus.flush) begin
          state_n = DRAIN;
        end else begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        csr_rrsp = bus.csr_rvalid;
        cnt_en   = 1'b1;
        if (bus.csr_rvalid) begin
          // a response racing a flush is acknowledged and dropped
          if (bus.flush) state_n = IDLE;
          else begin
            rsp_take = 1'b1;
            state_n  = RESP;
          end
        end else if (bus.flush) begin
          state_n = DRAIN;
        end else if (timeout_hit) begin
          to_take = 1'b1;
          state_n = RESP;
        end
      end
      RESP: begin
        wb_valid = !bus.flush;
        if (bus.flush || bus.wb_ready) state_n = IDLE;
      end
      DRAIN: begin
        csr_rrsp = bus.csr_rvalid;
        cnt_en   = 1'b1;
        if (bus.csr_rvalid || timeout_hit) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      addr_q       <= '0;
      op_q         <= '0;
      funct3_q     <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rd_q         <= '0;
      wb_data_q    <= '0;
      wb_exc_q     <= 1'b0;
      wb_timeout_q <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        addr_q       <= bus.req_csr_addr;
        op_q         <= dec_op;
        funct3_q     <= bus.req_funct3;
        imm_q        <= bus.req_rs1_idx;
        rs1_q        <= bus.req_rs1_val;
        rd_q         <= bus.req_rd_idx;
        wb_data_q    <= '0;
        wb_exc_q     <= dec_illegal;
        wb_timeout_q <= 1'b0;
        cnt          <= '0;
      end
      if (cnt_en) cnt <= cnt_inc;
      if (rsp_take) begin
        wb_data_q    <= REG_WIDTH'(bus.csr_rdata);
        wb_exc_q     <= bus.csr_reg_rsp;
        wb_timeout_q <= 1'b0;
      end
      if (to_take) begin
        wb_data_q    <= '0;
        wb_exc_q     <= 1'b1;
        wb_timeout_q <= 1'b1;
      end
    end
  end

  // command fields are only visible while a command is outstanding
  assign bus_active = (state == ISSUE) || (state == WAIT) || (state == DRAIN);

  assign bus.req_ready  = req_ready;
  assign bus.csr_valid  = csr_valid;
  assign bus.csr_rrsp   = csr_rrsp;
  assign bus.csr_addr   = bus_active ? addr_q   : '0;
  assign bus.csr_op     = bus_active ? op_q     : '0;
  assign bus.csr_funct3 = bus_active ? funct3_q : '0;
  assign bus.csr_imm    = bus_active ? imm_q    : '0;
  assign bus.rs1_val    = bus_active ? rs1_q    : '0;
  assign bus.wb_valid   = wb_valid;
  assign bus.wb_rd_idx  = rd_q;
  assign bus.wb_data    = wb_data_q;
  assign bus.wb_exc     = wb_exc_q;
  assign bus.wb_timeout = wb_timeout_q;
  assign dbg_state      = state;

  a_op_nonzero: assert property (@(posedge clk) disable iff (rst)
    csr_valid |-> (op_q != 2'b00));

endmodule
